// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, debounces a press,
// emits a single pulse per accepted key, then waits for a debounced release.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] keyboard_digit,
  output logic       digit_valid,
  output logic       enter_pulse,
  output logic       clear_pulse,
  output logic       key_down
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;
  typedef enum logic [1:0] {KEY_NONE, KEY_DIGIT, KEY_ENTER, KEY_CLEAR} key_kind_t;
  typedef struct packed {
    key_kind_t  kind;
    logic [3:0] digit;
  } key_t;

  state_t            state, state_nx;
  logic [1:0]        row, row_nx;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_nx;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_nx;
  logic [3:0]        col_p0, col_s;
  logic [3:0]        pattern;
  logic [3:0]        digit_q;
  key_t              emit_key;

  // Multi-key patterns (more than one low column) decode to KEY_NONE.
  function automatic key_t decode_key(input logic [1:0] r, input logic [3:0] pat);
    key_t       k;
    logic [1:0] c;
    logic       single;
    k.kind  = KEY_NONE;
    k.digit = 4'd0;
    c       = 2'd0;
    single  = 1'b1;
    case (pat)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      4'b0111: c = 2'd3;
      default: single = 1'b0;
    endcase
    if (single) begin
      if (r != 2'd3 && c != 2'd3) begin
        k.kind  = KEY_DIGIT;
        k.digit = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
      end else if (r == 2'd3) begin
        case (c)
          2'd0:    k.kind = KEY_CLEAR;
          2'd1:    k.kind = KEY_DIGIT;
          2'd2:    k.kind = KEY_ENTER;
          default: k.kind = KEY_NONE;
        endcase
      end
    end
    return k;
  endfunction

  assign emit_key = decode_key(row, pattern);

  // Column synchronizer: idles at all-released so reset never looks like a press
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_p0 <= 4'hF;
      col_s  <= 4'hF;
    end else begin
      col_p0 <= col_in;
      col_s  <= col_p0;
    end
  end

  always_ff @(posedge clock) begin
    if (state == SCAN && scan_cnt == SCAN_LAST && col_s != 4'hF)
      pattern <= col_s;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= SCAN;
      row      <= 2'd0;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      digit_q  <= 4'd0;
    end else begin
      state    <= state_nx;
      row      <= row_nx;
      scan_cnt <= scan_cnt_nx;
      deb_cnt  <= deb_cnt_nx;
      if (state == EMIT && emit_key.kind == KEY_DIGIT)
        digit_q <= emit_key.digit;
    end
  end

  always_comb begin
    state_nx    = state;
    row_nx      = row;
    scan_cnt_nx = scan_cnt;
    deb_cnt_nx  = deb_cnt;
    unique case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_nx = '0;
          if (col_s != 4'hF) begin
            state_nx   = DEBOUNCE;
            deb_cnt_nx = '0;
          end else begin
            row_nx = row + 2'd1;
          end
        end else begin
          scan_cnt_nx = scan_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s == pattern) begin
          if (deb_cnt == DEB_LAST) state_nx = EMIT;
          else                     deb_cnt_nx = deb_cnt + 1'b1;
        end else begin
          state_nx    = SCAN;
          scan_cnt_nx = '0;
        end
      end
      EMIT: begin
        state_nx   = RELEASE;
        deb_cnt_nx = '0;
      end
      RELEASE: begin
        if (col_s == 4'hF) begin
          if (deb_cnt == DEB_LAST) begin
            state_nx    = SCAN;
            row_nx      = row + 2'd1;
            scan_cnt_nx = '0;
            deb_cnt_nx  = '0;
          end else begin
            deb_cnt_nx = deb_cnt + 1'b1;
          end
        end else begin
          deb_cnt_nx = '0;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_comb begin
    row_out        = ~(4'b0001 << row);
    key_down       = (state != SCAN);
    keyboard_digit = digit_q;
    digit_valid    = 1'b0;
    enter_pulse    = 1'b0;
    clear_pulse    = 1'b0;
    if (state == EMIT) begin
      case (emit_key.kind)
        KEY_DIGIT: begin
          digit_valid    = 1'b1;
          keyboard_digit = emit_key.digit;
        end
        KEY_ENTER: enter_pulse = 1'b1;
        KEY_CLEAR: clear_pulse = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model closes row/column contacts, and a
// scoreboard queue pairs each expected key pulse with the one the DUT emits.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_DIGIT = 2'd1;
  localparam logic [1:0] K_ENTER = 2'd2;
  localparam logic [1:0] K_CLEAR = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] digit;
  } exp_t;

  typedef struct {
    logic [15:0] keys;
    logic [1:0]  kind;
    logic [3:0]  digit;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  keyboard_digit;
  logic        digit_valid;
  logic        enter_pulse;
  logic        clear_pulse;
  logic        key_down;

  logic [15:0] keys;
  logic [3:0]  last_digit;
  logic        seen_down;
  logic        mon_en;
  exp_t        q[$];
  vec_t        vecs[11];
  int          errors;
  int          checks;
  int          idle;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clock          (clock),
    .reset          (reset),
    .col_in         (col_in),
    .row_out        (row_out),
    .keyboard_digit (keyboard_digit),
    .digit_valid    (digit_valid),
    .enter_pulse    (enter_pulse),
    .clear_pulse    (clear_pulse),
    .key_down       (key_down)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Key index r*4+c pulls column c low whenever row r is the driven (low) row.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int key_row(input logic [15:0] k);
    for (int r = 0; r < 4; r++)
      if (k[r*4 +: 4] != 4'h0) return r;
    return 0;
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      logic [1:0] kind;
      exp_t       e;
      int         npulse;
      npulse = int'(digit_valid) + int'(enter_pulse) + int'(clear_pulse);
      check("row_one_cold", 32'(row_out == 4'b1110 || row_out == 4'b1101 ||
                                row_out == 4'b1011 || row_out == 4'b0111), 32'd1);
      check("pulse_overlap", 32'(npulse <= 1), 32'd1);
      if (key_down) seen_down = 1'b1;
      if (npulse != 0) begin
        kind = digit_valid ? K_DIGIT : (enter_pulse ? K_ENTER : K_CLEAR);
        if (q.size() == 0) begin
          check("unexpected_pulse", 32'(kind), 32'(K_NONE));
        end else begin
          e = q.pop_front();
          check("pulse_kind", 32'(kind), 32'(e.kind));
          check("pulse_digit", 32'(keyboard_digit), 32'(e.digit));
        end
      end
    end
  end

  task automatic press(input logic [15:0] k, input logic [1:0] kind, input logic [3:0] dg);
    exp_t e;
    @(posedge clock); #1;
    keys      = k;
    seen_down = 1'b0;
    if (kind != K_NONE) begin
      if (kind == K_DIGIT) last_digit = dg;
      e.kind  = kind;
      e.digit = last_digit;
      q.push_back(e);
    end
  endtask

  // Hold, release, then expect 2 sync + DEBOUNCE_CNT idle cycles before scanning moves on.
  task automatic hold_release(input logic [15:0] k, input int hold, output int idle_cycles);
    logic [3:0] er;
    repeat (hold) @(posedge clock);
    #1 keys = 16'h0;
    idle_cycles = 0;
    @(negedge clock);
    while (key_down && idle_cycles < 40) begin
      idle_cycles++;
      @(negedge clock);
    end
    check("release_idle", 32'(idle_cycles), 32'd10);
    er = 4'hF;
    er[(key_row(k) + 1) % 4] = 1'b0;
    check("resume_row", 32'(row_out), 32'(er));
    repeat (3) @(negedge clock);
    check("pulses_pending", 32'(q.size()), 32'd0);
    check("saw_key_down", 32'(seen_down), 32'd1);
    check("digit_hold", 32'(keyboard_digit), 32'(last_digit));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{16'h0010, K_DIGIT, 4'd4};
    vecs[1]  = '{16'h0040, K_DIGIT, 4'd6};
    vecs[2]  = '{16'h4000, K_ENTER, 4'd0};
    vecs[3]  = '{16'h1000, K_CLEAR, 4'd0};
    vecs[4]  = '{16'h0008, K_NONE,  4'd0};
    vecs[5]  = '{16'h0003, K_NONE,  4'd0};
    vecs[6]  = '{16'h0004, K_DIGIT, 4'd3};
    vecs[7]  = '{16'h0200, K_DIGIT, 4'd8};
    vecs[8]  = '{16'h8000, K_NONE,  4'd0};
    vecs[9]  = '{16'h0100, K_DIGIT, 4'd7};
    vecs[10] = '{16'h0800, K_NONE,  4'd0};

    errors     = 0;
    checks     = 0;
    keys       = 16'h0;
    last_digit = 4'd0;
    seen_down  = 1'b0;
    mon_en     = 1'b0;
    reset      = 1'b1;
    #1 reset   = 1'b0;
    #1;
    check("rst_row_out", 32'(row_out), 32'hE);
    check("rst_digit", 32'(keyboard_digit), 32'd0);
    check("rst_pulses", 32'({digit_valid, enter_pulse, clear_pulse}), 32'd0);
    check("rst_key_down", 32'(key_down), 32'd0);
    mon_en = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // '5' held long: still exactly one pulse
    press(16'h0020, K_DIGIT, 4'd5);
    hold_release(16'h0020, 200, idle);

    for (int i = 0; i < 11; i++) begin
      press(vecs[i].keys, vecs[i].kind, vecs[i].digit);
      hold_release(vecs[i].keys, 40, idle);
    end

    // '0' bouncing: contact toggles every 3 cycles, no pulse expected until stable
    @(posedge clock); #1;
    for (int p = 0; p < 10; p++) begin
      keys = (p % 2 == 0) ? 16'h2000 : 16'h0000;
      repeat (3) @(posedge clock);
      #1;
    end
    press(16'h2000, K_DIGIT, 4'd0);
    hold_release(16'h2000, 40, idle);

    // '9' interrupted by reset mid-debounce, then accepted once after reset
    press(16'h0400, K_NONE, 4'd0);
    for (int i = 0; i < 40 && !key_down; i++) @(negedge clock);
    check("debounce_entry", 32'(key_down), 32'd1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("abort_row_out", 32'(row_out), 32'hE);
    check("abort_key_down", 32'(key_down), 32'd0);
    check("abort_digit", 32'(keyboard_digit), 32'd0);
    last_digit = 4'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    begin
      exp_t e;
      e.kind  = K_DIGIT;
      e.digit = 4'd9;
      last_digit = 4'd9;
      q.push_back(e);
    end
    hold_release(16'h0400, 40, idle);

    repeat (5) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, SHALL set the clock cycles each row is driven during scanning (legal range 2..65535).
REQ-002 Parameter DEBOUNCE_CNT, default 20000, SHALL set the consecutive stable-sample cycles needed to accept a press or a release (legal range 2..2^20-1).
REQ-003 clock  input  1  SHALL be the single clock of the block; every register is clocked on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous and active-low.
REQ-005 col_in  input  4  SHALL carry the raw keypad column lines, active-low, asynchronous to clock.
REQ-006 row_out  output  4  SHALL drive the keypad rows, active-low one-cold: exactly one bit low at all times after reset.
REQ-007 keyboard_digit  output  4  SHALL carry the decimal value 0..9 of the last accepted digit key.
REQ-008 digit_valid  output  1  SHALL pulse high for one cycle per accepted digit key.
REQ-009 enter_pulse  output  1  SHALL pulse high for one cycle per accepted '#' key.
REQ-010 clear_pulse  output  1  SHALL pulse high for one cycle per accepted '*' key.
REQ-011 key_down  output  1  SHALL be high while the FSM is in DEBOUNCE, EMIT or RELEASE.

Function
REQ-012 col_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value col_s.
REQ-013 Key layout (row index r = 0..3 driven by row_out bit r, column index c = col_in bit c): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
REQ-014 FSM states SHALL be SCAN, DEBOUNCE, EMIT and RELEASE.
REQ-015 SCAN: the FSM SHALL drive row r for SCAN_DIV cycles, then advance to r+1, wrapping 3->0. On entry to a row, the row counter SHALL restart.
REQ-016 SCAN -> DEBOUNCE: when col_s != 4'b1111 on the last cycle of a row period, the FSM SHALL freeze the row and latch the pattern, and the debounce counter SHALL start at 0.
REQ-017 DEBOUNCE: if col_s equals the latched pattern, the counter SHALL increment; on any mismatch the FSM SHALL return to SCAN at the same row.
REQ-018 DEBOUNCE -> EMIT: when the counter reaches DEBOUNCE_CNT-1 with a matching sample.
REQ-019 EMIT: lasts exactly one cycle.
  - Pattern with exactly one low bit: decode via REQ-013.
    - Digit key: keyboard_digit SHALL update and digit_valid SHALL assert in this cycle.
    - '#': enter_pulse SHALL assert.
    - '*': clear_pulse SHALL assert.
    - A..D: no pulse.
  - Pattern with more than one low bit (multi-key): no pulse, no digit update.
  - The FSM SHALL then go to RELEASE.
REQ-020 RELEASE: the row SHALL stay frozen. The counter SHALL increment while col_s == 4'b1111 and reset to 0 otherwise. When the counter reaches DEBOUNCE_CNT-1, the FSM SHALL go to SCAN and advance to the next row.
REQ-021 At most one pulse output SHALL be high in any cycle; a held key SHALL produce exactly one pulse (no auto-repeat).
REQ-022 Press-to-pulse latency SHALL be at most 2 (sync) + 4*SCAN_DIV + DEBOUNCE_CNT + 1 cycles.
REQ-023 keyboard_digit SHALL hold its value between digit_valid pulses, including across enter_pulse and clear_pulse.
REQ-024 Counters SHALL be sized from the parameters and SHALL never wrap during DEBOUNCE or RELEASE.

Reset
REQ-025 While reset is low, and asynchronously on its assertion:
  - row_out = 4'b1110, keyboard_digit = 0, digit_valid = enter_pulse = clear_pulse = 0, key_down = 0.
  - State = SCAN, row = 0, all counters 0, synchronizer flops = 4'b1111.
REQ-026 Reset asserted in any state, including mid-DEBOUNCE or mid-RELEASE, SHALL abort the operation with no pulse; after release, scanning SHALL resume at row 0.

Verification
REQ-027 (SCAN_DIV=4, DEBOUNCE_CNT=8 for all scenarios.) Key '5' (row1, col1) held 200 cycles, then released -> exactly one digit_valid pulse with keyboard_digit=5; row_out returns to scanning after 8 idle cycles.
REQ-028 Keys '4', '6', '#' pressed and released in sequence -> digit_valid with 4, digit_valid with 6, then enter_pulse; keyboard_digit stays 6 after enter_pulse.
REQ-029 Key '0' bouncing (col1 toggling every 3 cycles for 30 cycles) then stable 20 cycles -> one digit_valid with 0, none during the bounce.
REQ-030 '1' and '2' pressed together (row0, col_in=4'b1100) -> no pulse, key_down high; after release, scanning resumes.
REQ-031 '*' pressed -> clear_pulse only. 'A' pressed -> no pulse at all.
REQ-032 Reset driven low mid-DEBOUNCE of key '9' -> no pulse, row_out=4'b1110 immediately; after reset is released with '9' still held, exactly one digit_valid with 9.
